// File: rtl/seq_det_ctrl.sv
// Frame sequencer for the serial sequence detector: accepts parallel words over
// valid/ready, serializes them MSB-first onto det_din as a gap-free stream,
// clears the detector per frame and counts its hit pulses with saturation.
module seq_det_ctrl #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned DET_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       cfg_words,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             det_clr,
  output logic             det_din,
  input  logic             det_dout,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] hit_count,
  output logic             overflow,
  output logic             underrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_FILL,
    S_SHIFT,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int unsigned      BCNT_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(WIDTH - 1);
  localparam logic [2:0]       DRAIN_LAST = 3'(DET_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t             state;
  logic [7:0]         words_left;
  logic [7:0]         acc_left;
  logic [WIDTH-1:0]   hold_q;
  logic               hold_v;
  // det_din is the registered MSB; shreg carries only the bits still to go.
  logic [WIDTH-2:0]   shreg;
  logic [BCNT_W-1:0]  bcnt;
  logic [2:0]         dcnt;
  logic               accept;
  logic               hold_take;
  logic               last_bit;
  logic               frame_start;
  logic               counting;

  assign s_ready     = ((state == S_FILL) || (state == S_SHIFT)) && !hold_v && (acc_left != '0);
  assign accept      = s_ready && s_valid;
  assign last_bit    = (state == S_SHIFT) && (bcnt == BCNT_LAST);
  assign hold_take   = hold_v && ((state == S_FILL) || (last_bit && (words_left != '0)));
  assign frame_start = (state == S_IDLE) && start;
  assign counting    = (state == S_SHIFT) || (state == S_DRAIN);

  // One-word hold register between the upstream handshake and the shifter
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q   <= '0;
      hold_v   <= 1'b0;
      acc_left <= '0;
    end else begin
      if (frame_start) begin
        acc_left <= cfg_words;
      end else if (accept) begin
        acc_left <= acc_left - 8'd1;
      end
      if (accept) begin
        hold_q <= s_data;
        hold_v <= 1'b1;
      end else if (hold_take) begin
        hold_v <= 1'b0;
      end
    end
  end

  // Saturating hit counter, sampled only while bits or drain cycles are live
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count <= '0;
      overflow  <= 1'b0;
    end else if (frame_start) begin
      hit_count <= '0;
      overflow  <= 1'b0;
    end else if (counting && det_dout) begin
      if (hit_count == CNT_MAX) begin
        overflow <= 1'b1;
      end else begin
        hit_count <= hit_count + 1'b1;
      end
    end
  end

  // Frame FSM with registered detector-side outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      words_left <= '0;
      shreg      <= '0;
      bcnt       <= '0;
      dcnt       <= '0;
      det_clr    <= 1'b0;
      det_din    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      det_clr <= 1'b0;
      done    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_CLR;
            words_left <= cfg_words;
            underrun   <= 1'b0;
            det_clr    <= 1'b1;
            busy       <= 1'b1;
          end
        end
        S_CLR: begin
          if (words_left == '0) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state <= S_FILL;
          end
        end
        S_FILL: begin
          det_din <= 1'b0;
          if (hold_v) begin
            det_din    <= hold_q[WIDTH-1];
            shreg      <= hold_q[WIDTH-2:0];
            bcnt       <= '0;
            words_left <= words_left - 8'd1;
            state      <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (bcnt == BCNT_LAST) begin
            if (words_left == '0) begin
              state   <= S_DRAIN;
              det_din <= 1'b0;
              dcnt    <= '0;
            end else if (hold_v) begin
              // back-to-back reload keeps the stream contiguous
              det_din    <= hold_q[WIDTH-1];
              shreg      <= hold_q[WIDTH-2:0];
              bcnt       <= '0;
              words_left <= words_left - 8'd1;
            end else begin
              underrun <= 1'b1;
              det_din  <= 1'b0;
              state    <= S_FILL;
            end
          end else begin
            det_din <= shreg[WIDTH-2];
            shreg   <= shreg << 1;
            bcnt    <= bcnt + 1'b1;
          end
        end
        S_DRAIN: begin
          if (dcnt == DRAIN_LAST) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            dcnt <= dcnt + 3'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Self-checking bench for seq_det_ctrl: frames are described by word lists,
// optional delivery gap, optional mid-frame reset and hit-pulse schedule; the
// expected bit stream, strobes and counts are derived per cycle from those.
module tb_seq_det_ctrl;

  localparam int W    = 8;
  localparam int CW   = 2;
  localparam int DL   = 1;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [7:0]    cfg_words;
  logic [W-1:0]  s_data;
  logic          s_valid;
  logic          s_ready;
  logic          det_clr;
  logic          det_din;
  logic          det_dout;
  logic          busy;
  logic          done;
  logic [CW-1:0] hit_count;
  logic          overflow;
  logic          underrun;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] wq [0:15];
  int           pulse_at [0:7];
  int           npulse = 0;

  always #5 clk = ~clk;

  seq_det_ctrl #(
    .WIDTH  (W),
    .CNT_W  (CW),
    .DET_LAT(DL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cfg_words(cfg_words),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .det_clr  (det_clr),
    .det_din  (det_din),
    .det_dout (det_dout),
    .busy     (busy),
    .done     (done),
    .hit_count(hit_count),
    .overflow (overflow),
    .underrun (underrun)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"},     32'(busy),      32'd0);
    chk({tag, "_done"},     32'(done),      32'd0);
    chk({tag, "_det_clr"},  32'(det_clr),   32'd0);
    chk({tag, "_det_din"},  32'(det_din),   32'd0);
    chk({tag, "_s_ready"},  32'(s_ready),   32'd0);
    chk({tag, "_hits"},     32'(hit_count), 32'd0);
    chk({tag, "_overflow"}, 32'(overflow),  32'd0);
    chk({tag, "_underrun"}, 32'(underrun),  32'd0);
  endtask

  // gap >= 0: word 1 is withheld until gap cycles past word 0's last bit (n == 2 only).
  // abort_at >= 0: rst is driven in that cycle. hmode 0: random hits, 1: pulse_at list.
  task automatic run_frame(input int n, input int gap, input int abort_at,
                           input int hmode, input bit noisy_start);
    int   bst [16];
    int   e_end;
    int   d_step;
    int   hits;
    int   acc;
    int   last;
    int   exp_hits;
    bit   in_bit;
    bit   cnt_win;
    logic eb;

    for (int k = 0; k < n; k++) begin
      if (k == 0)                   bst[k] = 4;
      else if (k == 1 && gap >= 0)  bst[k] = 5 + W + gap;
      else                          bst[k] = bst[k-1] + W;
    end
    e_end     = (n == 0) ? 0 : bst[n-1] + W;
    d_step    = (n == 0) ? 2 : e_end + DL;
    hits      = 0;
    acc       = 0;
    cfg_words = 8'(n);
    last      = (abort_at >= 0) ? abort_at + 1 : d_step + 1;

    for (int r = 0; r <= last; r++) begin
      @(negedge clk);
      in_bit = 1'b0;
      eb     = 1'b0;
      for (int k = 0; k < n; k++) begin
        if (r >= bst[k] && r < bst[k] + W) begin
          in_bit = 1'b1;
          eb     = wq[k][W-1-(r-bst[k])];
        end
      end

      if (abort_at >= 0 && r == abort_at + 1) begin
        chk_reset_vals("after_rst");
      end else begin
        exp_hits = (hits > CMAX) ? CMAX : hits;
        chk("busy",    32'(busy),    32'(r >= 1 && r <= d_step));
        chk("det_clr", 32'(det_clr), 32'(r == 1));
        chk("done",    32'(done),    32'(r == d_step));
        chk("det_din", 32'(det_din), 32'(eb));
        if (r <= 2 || n == 0)
          chk("s_ready", 32'(s_ready), 32'(r == 2 && n > 0));
        if (r == 1) begin
          chk("start_hits", 32'(hit_count), 32'd0);
          chk("start_ovf",  32'(overflow),  32'd0);
          chk("start_udr",  32'(underrun),  32'd0);
        end
        if (r == d_step || r == d_step + 1) begin
          chk("hit_count", 32'(hit_count), 32'(exp_hits));
          chk("overflow",  32'(overflow),  32'(hits > CMAX));
          chk("underrun",  32'(underrun),  32'(gap >= 0));
        end
      end

      rst   = (r == abort_at);
      start = (r == 0) || (noisy_start && r >= 1 && r < last && $urandom_range(3) == 0);
      if (acc < n && (gap < 0 || acc != 1 || r >= 3 + W + gap)) begin
        s_valid = 1'b1;
        s_data  = wq[acc];
      end else begin
        s_valid = 1'b0;
        s_data  = W'($urandom);
      end
      if (s_valid && s_ready) acc++;
      if (hmode == 0) begin
        det_dout = ($urandom_range(15) == 0);
      end else begin
        det_dout = 1'b0;
        for (int p = 0; p < npulse; p++)
          if (pulse_at[p] == r) det_dout = 1'b1;
      end
      cnt_win = (n > 0) && (in_bit || (r >= e_end && r < e_end + DL));
      if (cnt_win && det_dout && r != abort_at) hits++;
    end
    rst      = 1'b0;
    start    = 1'b0;
    s_valid  = 1'b0;
    det_dout = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int gap;
    int ab;

    rst       = 1'b1;
    start     = 1'b0;
    cfg_words = '0;
    s_data    = '0;
    s_valid   = 1'b0;
    det_dout  = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;

    // basic two-word frame with three hits during shifting
    wq[0] = 8'hA5;
    wq[1] = 8'h3C;
    npulse = 3;
    pulse_at[0] = 5; pulse_at[1] = 9; pulse_at[2] = 15;
    run_frame(2, -1, -1, 1, 1'b0);

    // second word arrives late: gap of zeros and sticky underrun
    wq[0] = 8'hF0;
    wq[1] = 8'h81;
    npulse = 0;
    run_frame(2, 5, -1, 1, 1'b0);

    // hit in drain counted, hits in done and idle ignored
    wq[0] = 8'h5A;
    npulse = 3;
    pulse_at[0] = 12; pulse_at[1] = 13; pulse_at[2] = 14;
    run_frame(1, -1, -1, 1, 1'b0);

    // five hits into a 2-bit counter
    wq[0] = 8'hC3;
    npulse = 5;
    for (int p = 0; p < 5; p++) pulse_at[p] = 4 + p;
    run_frame(1, -1, -1, 1, 1'b0);

    // zero-length frame
    run_frame(0, -1, -1, 0, 1'b0);

    // reset during shifting with a word held, then a clean frame; starts mid-frame ignored
    for (int k = 0; k < 3; k++) wq[k] = W'($urandom);
    run_frame(3, -1, 10, 0, 1'b1);
    repeat (2) @(negedge clk);
    wq[0] = 8'h96;
    wq[1] = 8'h0F;
    run_frame(2, -1, -1, 0, 1'b1);

    // randomized frames
    for (int f = 0; f < 40; f++) begin
      n = $urandom_range(4);
      for (int k = 0; k < n; k++) wq[k] = W'($urandom);
      gap = (n == 2 && $urandom_range(3) == 0) ? int'($urandom_range(4)) : -1;
      ab  = (n > 0 && gap < 0 && $urandom_range(4) == 0) ? int'($urandom_range(3 + W * n, 1)) : -1;
      run_frame(n, gap, ab, 0, 1'($urandom_range(1)));
      repeat ($urandom_range(2)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
